pamac_seq_ctrl: RTL and testbench
=================================

PAMAC_SEQ_CTRL -- requirements
Module: pamac_seq_ctrl

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port in_valid  input  1  operand set (ETC, mode) offered.
REQ-004 SHALL have port in_ready  output  1  controller accepts the operand set this cycle.
REQ-005 SHALL have port ETC_A  input  4  essential-term count of activation.
REQ-006 SHALL have port ETC_W  input  4  essential-term count of weight.
REQ-007 SHALL have port MDecomp  input  1  1 = decomposed multi-cycle multiply, 0 = single-cycle multiply.
REQ-008 SHALL have port AWDecomp  input  1  1 = decompose weight (use ETC_W), 0 = decompose activation (use ETC_A).
REQ-009 SHALL have port flush  input  1  synchronous abort of the current operation.
REQ-010 SHALL have port BPEB_sel  output  3  bit-pair term index driven to the MAC.
REQ-011 SHALL have port DFF_en  output  1  MAC accumulator register enable.
REQ-012 SHALL have port first_cycle  output  1  MAC adds external partial sum T this cycle.
REQ-013 SHALL have port MDecomp_o  output  1  registered MDecomp of the operation in flight.
REQ-014 SHALL have port AWDecomp_o  output  1  registered AWDecomp of the operation in flight.
REQ-015 SHALL have port out_valid  output  1  MAC result Y is final.
REQ-016 SHALL have port out_zero  output  1  with out_valid: operation skipped, result equals T unchanged.
REQ-017 SHALL have port out_ready  input  1  consumer accepts the result.

Function
REQ-018 SHALL implement states IDLE, RUN, DONE.
REQ-019 SHALL assert in_ready only in IDLE; handshake fires when in_valid and in_ready both high.
REQ-020 SHALL on handshake latch MDecomp, AWDecomp and term length LEN: MDecomp=0 -> LEN=1; MDecomp=1 -> LEN = min(AWDecomp ? ETC_W : ETC_A, 8).
REQ-021 SHALL on handshake with LEN=0 go directly to DONE with out_zero=1, no DFF_en pulse.
REQ-022 SHALL on handshake with LEN>=1 go to RUN with term counter cleared to 0.
REQ-023 SHALL in RUN drive BPEB_sel = counter, DFF_en=1, first_cycle=1 only when counter=0; exactly LEN RUN cycles.
REQ-024 SHALL increment counter each RUN cycle; on counter=LEN-1 transition to DONE (3-bit wrap at LEN=8 harmless, exit decided by compare).
REQ-025 SHALL in IDLE and DONE drive DFF_en=0, first_cycle=0, BPEB_sel=0.
REQ-026 SHALL in DONE hold out_valid=1 and out_zero stable until out_ready=1, then return to IDLE next cycle.
REQ-027 SHALL NOT accept a new operand set in the cycle DONE is left (in_ready rises one cycle later, in IDLE).
REQ-028 SHALL keep MDecomp_o/AWDecomp_o constant from handshake until the next handshake.
REQ-029 SHALL on flush=1 in any state go to IDLE next cycle, DFF_en=0 that next cycle, out_valid dropped; flush has priority over handshake and out_ready.
REQ-030 SHALL ignore in_valid, ETC_A, ETC_W, MDecomp, AWDecomp outside the handshake cycle.
REQ-031 SHALL register all outputs except in_ready (decoded from state); no combinational path from inputs to outputs.
REQ-032 SHALL give latency from handshake to out_valid of LEN+1 cycles (1 cycle for LEN=0).

Reset
REQ-033 SHALL on rst_n=0 immediately force IDLE, counter=0, BPEB_sel=0, DFF_en=0, first_cycle=0, out_valid=0, out_zero=0, MDecomp_o=0, AWDecomp_o=0.
REQ-034 SHALL abandon any operation in progress on reset mid-RUN or mid-DONE with no further DFF_en pulse.
REQ-035 SHALL assert in_ready in the first cycle after rst_n deasserts.

Verification
REQ-036 SHALL cover: MDecomp=1, AWDecomp=1, ETC_W=3 -> BPEB_sel 0,1,2 with DFF_en=1, first_cycle only on 0, out_valid 4 cycles after handshake.
REQ-037 SHALL cover: MDecomp=1, AWDecomp=0, ETC_A=0 -> no DFF_en, out_valid+out_zero next cycle.
REQ-038 SHALL cover: ETC_A=12 with AWDecomp=0 -> clamped to 8 terms, BPEB_sel 0..7, then DONE.
REQ-039 SHALL cover: MDecomp=0 -> one RUN cycle, BPEB_sel=0, first_cycle=1, out_valid next cycle.
REQ-040 SHALL cover: out_ready held low 5 cycles in DONE -> out_valid held, in_ready low, then IDLE one cycle after out_ready.
REQ-041 SHALL cover: flush at RUN counter=2 of LEN=6, and rst_n low at counter=4 of another run -> IDLE, DFF_en=0 next cycle/immediately, in_ready restored.

Source files
------------

// File: rtl/pamac_seq_ctrl.sv
// Sequencing controller for a bit-pair decomposed MAC: accepts one operand set,
// walks the essential-term index for LEN cycles, then holds the result until consumed.
module pamac_seq_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] ETC_A,
    input  logic [3:0] ETC_W,
    input  logic       MDecomp,
    input  logic       AWDecomp,
    input  logic       flush,
    output logic [2:0] BPEB_sel,
    output logic       DFF_en,
    output logic       first_cycle,
    output logic       MDecomp_o,
    output logic       AWDecomp_o,
    output logic       out_valid,
    output logic       out_zero,
    input  logic       out_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [3:0] len_q, len_d;
    logic [2:0] sel_q, sel_d;
    logic       dff_en_q, dff_en_d;
    logic       first_q, first_d;
    logic       mdec_q, mdec_d;
    logic       awdec_q, awdec_d;
    logic       valid_q, valid_d;
    logic       zero_q, zero_d;
    logic [3:0] new_len_s;
    logic       last_term_s;

    // Number of MAC cycles for an operand set; a term count above 8 saturates.
    function automatic logic [3:0] term_len(input logic md, input logic aw,
                                            input logic [3:0] ea, input logic [3:0] ew);
        logic [3:0] etc;
        etc = aw ? ew : ea;
        if (!md) begin
            return 4'd1;
        end else if (etc > 4'd8) begin
            return 4'd8;
        end else begin
            return etc;
        end
    endfunction

    assign new_len_s   = term_len(MDecomp, AWDecomp, ETC_A, ETC_W);
    assign last_term_s = ({1'b0, cnt_q} == (len_q - 4'd1));
    assign in_ready    = (state_q == IDLE);

    // Next state and next registered outputs; flush overrides everything else.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        mdec_d   = mdec_q;
        awdec_d  = awdec_q;
        sel_d    = 3'd0;
        dff_en_d = 1'b0;
        first_d  = 1'b0;
        valid_d  = 1'b0;
        zero_d   = 1'b0;
        if (flush) begin
            state_d = IDLE;
            cnt_d   = 3'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        len_d   = new_len_s;
                        mdec_d  = MDecomp;
                        awdec_d = AWDecomp;
                        cnt_d   = 3'd0;
                        if (new_len_s == 4'd0) begin
                            state_d = DONE;
                            valid_d = 1'b1;
                            zero_d  = 1'b1;
                        end else begin
                            state_d  = RUN;
                            dff_en_d = 1'b1;
                            first_d  = 1'b1;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                RUN: begin
                    // Exit is decided by compare, so the counter wrap at LEN=8 is harmless.
                    if (last_term_s) begin
                        state_d = DONE;
                        cnt_d   = 3'd0;
                        valid_d = 1'b1;
                    end else begin
                        cnt_d    = cnt_q + 3'd1;
                        sel_d    = cnt_q + 3'd1;
                        dff_en_d = 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end else begin
                        valid_d = 1'b1;
                        zero_d  = zero_q;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = 3'd0;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= 3'd0;
            len_q    <= 4'd0;
            sel_q    <= 3'd0;
            dff_en_q <= 1'b0;
            first_q  <= 1'b0;
            mdec_q   <= 1'b0;
            awdec_q  <= 1'b0;
            valid_q  <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            sel_q    <= sel_d;
            dff_en_q <= dff_en_d;
            first_q  <= first_d;
            mdec_q   <= mdec_d;
            awdec_q  <= awdec_d;
            valid_q  <= valid_d;
            zero_q   <= zero_d;
        end
    end

    assign BPEB_sel    = sel_q;
    assign DFF_en      = dff_en_q;
    assign first_cycle = first_q;
    assign MDecomp_o   = mdec_q;
    assign AWDecomp_o  = awdec_q;
    assign out_valid   = valid_q;
    assign out_zero    = zero_q;

endmodule

// File: tb/tb_pamac_seq_ctrl.sv
// Scoreboard bench for pamac_seq_ctrl: a timestamped transaction model predicts
// every MAC term pulse and result; a negedge monitor pops and compares.
module tb_pamac_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] ETC_A = 4'd0;
    logic [3:0] ETC_W = 4'd0;
    logic       MDecomp = 1'b0;
    logic       AWDecomp = 1'b0;
    logic       flush = 1'b0;
    logic [2:0] BPEB_sel;
    logic       DFF_en;
    logic       first_cycle;
    logic       MDecomp_o;
    logic       AWDecomp_o;
    logic       out_valid;
    logic       out_zero;
    logic       out_ready = 1'b0;

    pamac_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .ETC_A(ETC_A), .ETC_W(ETC_W), .MDecomp(MDecomp), .AWDecomp(AWDecomp),
        .flush(flush), .BPEB_sel(BPEB_sel), .DFF_en(DFF_en), .first_cycle(first_cycle),
        .MDecomp_o(MDecomp_o), .AWDecomp_o(AWDecomp_o), .out_valid(out_valid),
        .out_zero(out_zero), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_res;
        int cyc;
        int sel;
        bit first;
        bit zero;
    } item_t;

    item_t sb[$];
    int    n_vec = 0;
    int    n_err = 0;
    int    cyc = 0;
    bit    m_idle = 1'b1;
    bit    m_md = 1'b0;
    bit    m_aw = 1'b0;
    bit    m_zero = 1'b0;
    bit    exp_ov = 1'b0;
    int    m_res = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Transaction-level model: cycle stamps of each term and of the result.
    task automatic model_edge();
        int etc;
        int len;
        item_t it;
        if (!rst_n || flush) begin
            sb.delete();
            m_idle = 1'b1;
            if (!rst_n) begin
                m_md = 1'b0;
                m_aw = 1'b0;
            end
        end else if (m_idle && in_valid) begin
            etc = AWDecomp ? int'(ETC_W) : int'(ETC_A);
            len = !MDecomp ? 1 : (etc > 8 ? 8 : etc);
            for (int i = 0; i < len; i++) begin
                it = '{is_res: 1'b0, cyc: cyc + i, sel: i, first: (i == 0), zero: 1'b0};
                sb.push_back(it);
            end
            it = '{is_res: 1'b1, cyc: cyc + len, sel: 0, first: 1'b0, zero: (len == 0)};
            sb.push_back(it);
            m_res  = cyc + len;
            m_idle = 1'b0;
            m_md   = MDecomp;
            m_aw   = AWDecomp;
            m_zero = (len == 0);
        end else if (!m_idle && cyc > m_res && out_ready) begin
            m_idle = 1'b1;
        end
        exp_ov = !m_idle && (cyc >= m_res);
    endtask

    task automatic step(input bit iv, input logic [3:0] ea, input logic [3:0] ew,
                        input bit md, input bit aw, input bit fl, input bit ordy);
        in_valid  = iv;
        ETC_A     = ea;
        ETC_W     = ew;
        MDecomp   = md;
        AWDecomp  = aw;
        flush     = fl;
        out_ready = ordy;
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
    endtask

    task automatic idle_step();
        step(1'b0, 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b0);
    endtask

    // Busy cycles carry random junk on the operand pins to show they are ignored.
    task automatic busy_step(input int dly);
        step(1'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
             1'b0, (cyc >= m_res + dly));
    endtask

    task automatic run_op(input logic [3:0] ea, input logic [3:0] ew, input bit md,
                          input bit aw, input int dly);
        step(1'b1, ea, ew, md, aw, 1'b0, 1'b0);
        for (int k = 0; k < 60 && !m_idle; k++) busy_step(dly);
        check("op_complete_bound", int'(m_idle), 1);
        idle_step();
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        sb.delete();
        m_idle = 1'b1;
        m_md   = 1'b0;
        m_aw   = 1'b0;
        exp_ov = 1'b0;
        #1;
        check("rst_dff_en", int'(DFF_en), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_in_ready", int'(in_ready), 1);
        idle_step();
        idle_step();
        rst_n = 1'b1;
        idle_step();
    endtask

    // Monitor: per-cycle flags plus scoreboard pops on every term pulse and new result.
    initial begin : monitor
        bit ov_prev = 1'b0;
        item_t it;
        forever begin
            @(negedge clk);
            check("in_ready", int'(in_ready), int'(m_idle));
            check("out_valid", int'(out_valid), int'(exp_ov));
            check("out_zero", int'(out_zero), int'(exp_ov && m_zero));
            check("MDecomp_o", int'(MDecomp_o), int'(m_md));
            check("AWDecomp_o", int'(AWDecomp_o), int'(m_aw));
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                check("missed_event_cycle", sb[0].cyc, cyc);
                void'(sb.pop_front());
            end
            if (DFF_en) begin
                if (sb.size() == 0) begin
                    check("unexpected_dff_en", 1, 0);
                end else begin
                    it = sb.pop_front();
                    check("term_kind", int'(it.is_res), 0);
                    check("term_cycle", cyc, it.cyc);
                    check("BPEB_sel", int'(BPEB_sel), it.sel);
                    check("first_cycle", int'(first_cycle), int'(it.first));
                end
            end else begin
                check("idle_BPEB_sel", int'(BPEB_sel), 0);
                check("idle_first_cycle", int'(first_cycle), 0);
            end
            if (out_valid && !ov_prev) begin
                if (sb.size() == 0) begin
                    check("unexpected_out_valid", 1, 0);
                end else begin
                    it = sb.pop_front();
                    check("result_kind", int'(it.is_res), 1);
                    check("result_cycle", cyc, it.cyc);
                    check("result_zero", int'(out_zero), int'(it.zero));
                end
            end
            ov_prev = out_valid;
        end
    end

    initial begin : stimulus
        repeat (2) idle_step();
        rst_n = 1'b1;
        idle_step();
        check("in_ready_after_reset", int'(in_ready), 1);

        run_op(4'd0, 4'd3, 1'b1, 1'b1, 0);
        run_op(4'd0, 4'd9, 1'b1, 1'b0, 0);
        run_op(4'd12, 4'd1, 1'b1, 1'b0, 0);
        run_op(4'd7, 4'd7, 1'b0, 1'b1, 0);
        run_op(4'd8, 4'd15, 1'b1, 1'b1, 0);
        run_op(4'd5, 4'd2, 1'b1, 1'b0, 5);
        run_op(4'd3, 4'd0, 1'b1, 1'b1, 3);

        // Flush at term index 2 of a six-term run.
        step(1'b1, 4'd0, 4'd6, 1'b1, 1'b1, 1'b0, 1'b0);
        idle_step();
        idle_step();
        check("pre_flush_sel", int'(BPEB_sel), 2);
        step(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle_step();

        // Flush wins over a simultaneous handshake, and over out_ready in DONE.
        step(1'b1, 4'd4, 4'd4, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle_step();

        // Asynchronous reset while at term index 4.
        step(1'b1, 4'd6, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (4) idle_step();
        check("pre_reset_sel", int'(BPEB_sel), 4);
        do_reset();
        run_op(4'd2, 4'd0, 1'b1, 1'b0, 1);

        // Reset while holding a result.
        step(1'b1, 4'd1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) idle_step();
        do_reset();

        for (int i = 0; i < 400; i++) begin
            step(1'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 19) == 0), 1'($urandom));
        end
        step(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        repeat (3) idle_step();
        check("drained_scoreboard", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
